// File: rtl/serial_word_receiver_if.sv
// Receiver-side bundle: serial line in, CPU-facing word/valid/status out.
interface serial_word_receiver_if;
    logic        RX;
    logic        Read_Ack;
    logic [15:0] SerialRead;
    logic        SerialValid;
    logic        Overrun;
    logic        Frame_Error;
    logic        Busy;

    modport master (
        output RX, Read_Ack,
        input  SerialRead, SerialValid, Overrun, Frame_Error, Busy
    );

    modport slave (
        input  RX, Read_Ack,
        output SerialRead, SerialValid, Overrun, Frame_Error, Busy
    );
endinterface

// File: rtl/serial_word_receiver.sv
// 8N1 receiver that pairs two bytes (low first) into a 16-bit word held until the CPU acks it.
module serial_word_receiver #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned GAP_BITS     = 20
) (
    input logic                   Clock,
    input logic                   Reset,
    serial_word_receiver_if.slave bus
);
    localparam int unsigned CntW      = $clog2(CLKS_PER_BIT);
    localparam int unsigned GapCycles = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned GapW      = $clog2(GapCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic            rx_meta_q, line;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            ferr_wait_q, ferr_wait_d;
    logic            byte_done, frame_err;

    logic            pair_high_q;
    logic [7:0]      low_q;
    logic [GapW-1:0] gap_q;
    logic [15:0]     word_q;
    logic            valid_q, overrun_q, ferr_q;
    logic            start_seen;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rx_meta_q   <= 1'b1;
            line        <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            ferr_wait_q <= 1'b0;
        end else begin
            rx_meta_q   <= bus.RX;
            line        <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            ferr_wait_q <= ferr_wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        ferr_wait_d = ferr_wait_q;
        byte_done   = 1'b0;
        frame_err   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!line) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    if (line) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                // After a bad stop bit, hold here until the line returns high.
                if (ferr_wait_q) begin
                    if (line) begin
                        state_d     = StIdle;
                        ferr_wait_d = 1'b0;
                    end
                end else if (cnt_q == CntLast) begin
                    if (line) begin
                        byte_done = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        frame_err   = 1'b1;
                        ferr_wait_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign start_seen = (state_q == StIdle) && !line;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pair_high_q <= 1'b0;
            low_q       <= '0;
            gap_q       <= '0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            ferr_q    <= frame_err;

            if (start_seen) begin
                gap_q <= '0;
            end else if (state_q == StIdle && pair_high_q) begin
                gap_q <= gap_q + GapW'(1);
            end

            if (frame_err) begin
                pair_high_q <= 1'b0;
            end else if (byte_done) begin
                if (!pair_high_q) begin
                    low_q       <= shift_q;
                    pair_high_q <= 1'b1;
                    gap_q       <= '0;
                end else begin
                    word_q      <= {shift_q, low_q};
                    pair_high_q <= 1'b0;
                end
            end else if (state_q == StIdle && pair_high_q && gap_q == GapLast) begin
                pair_high_q <= 1'b0;
            end

            // A completing word beats a same-cycle ack; only an unacked overwrite is an overrun.
            if (byte_done && pair_high_q) begin
                valid_q   <= 1'b1;
                overrun_q <= valid_q && !bus.Read_Ack;
            end else if (bus.Read_Ack && valid_q) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.SerialRead  = word_q;
    assign bus.SerialValid = valid_q;
    assign bus.Overrun     = overrun_q;
    assign bus.Frame_Error = ferr_q;
    assign bus.Busy        = (state_q != StIdle);
endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed and randomized bench for serial_word_receiver against a byte-level pairing model.
module tb_serial_word_receiver;
    localparam int unsigned Cpb = 16;
    localparam int unsigned Gap = 2;

    logic clk;
    logic rst;
    serial_word_receiver_if bus();

    serial_word_receiver #(
        .CLKS_PER_BIT(Cpb),
        .GAP_BITS    (Gap)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ovr_seen = 0;
    int ferr_seen = 0;

    always @(negedge clk) begin
        if (bus.Overrun)     ovr_seen  <= ovr_seen + 1;
        if (bus.Frame_Error) ferr_seen <= ferr_seen + 1;
    end

    // Byte-level model: pending low byte, held word, valid flag, expected pulse counts.
    logic        m_pend_valid;
    logic [7:0]  m_pend;
    logic [15:0] m_word;
    logic        m_valid;
    int          m_ovr;
    int          m_ferr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend_valid = 1'b0;
        m_pend       = '0;
        m_word       = '0;
        m_valid      = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit ack);
        if (!stop_ok) begin
            m_ferr++;
            m_pend_valid = 1'b0;
            if (ack) m_valid = 1'b0;
        end else if (m_pend_valid) begin
            if (m_valid && !ack) m_ovr++;
            m_word       = {b, m_pend};
            m_valid      = 1'b1;
            m_pend_valid = 1'b0;
        end else begin
            m_pend       = b;
            m_pend_valid = 1'b1;
            if (ack) m_valid = 1'b0;
        end
    endtask

    // Half a stop bit is already spent idle when the receiver returns to IDLE.
    task automatic model_idle(input int bits);
        if (m_pend_valid && (bits * Cpb + Cpb / 2 >= Gap * Cpb)) m_pend_valid = 1'b0;
    endtask

    task automatic idle_bits(input int bits);
        model_idle(bits);
        bus.RX = 1'b1;
        repeat (bits * Cpb) @(negedge clk);
    endtask

    // Drives one frame starting at a falling edge; c counts posedges since the start bit fell.
    task automatic send_frame(input logic [7:0] b, input int stop_low_bits,
                              input bit ack_at_done, input bit chk_lat);
        int nbits;
        int bi;
        nbits = 10 + stop_low_bits;
        for (int c = 0; c < nbits * Cpb; c++) begin
            @(negedge clk);
            bi = c / Cpb;
            if (bi == 0)                      bus.RX = 1'b0;
            else if (bi <= 8)                 bus.RX = b[bi-1];
            else if (bi < 9 + stop_low_bits)  bus.RX = 1'b0;
            else                              bus.RX = 1'b1;
            if (c == 154) begin
                bus.Read_Ack = ack_at_done;
                if (chk_lat) check("valid_before_latency", 32'(bus.SerialValid), 32'd0);
            end
            if (c == 155) begin
                bus.Read_Ack = 1'b0;
                if (chk_lat) check("valid_at_latency", 32'(bus.SerialValid), 32'd1);
            end
        end
        model_frame(b, stop_low_bits == 0, ack_at_done);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        bus.Read_Ack = 1'b1;
        @(negedge clk);
        bus.Read_Ack = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic check_model(input string tag);
        @(negedge clk);
        check({tag, "_word"},  32'(bus.SerialRead),  32'(m_word));
        check({tag, "_valid"}, 32'(bus.SerialValid), 32'(m_valid));
        check({tag, "_ovr"},   32'(ovr_seen),        32'(m_ovr));
        check({tag, "_ferr"},  32'(ferr_seen),       32'(m_ferr));
    endtask

    initial begin
        logic [7:0] lo, hi;
        int mode;
        int pre_ferr;
        bit pre_valid;
        m_ovr  = 0;
        m_ferr = 0;
        model_reset();
        rst = 1'b1;
        bus.RX = 1'b1;
        bus.Read_Ack = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_word",  32'(bus.SerialRead),  32'd0);
        check("rst_valid", 32'(bus.SerialValid), 32'd0);
        check("rst_ovr",   32'(bus.Overrun),     32'd0);
        check("rst_ferr",  32'(bus.Frame_Error), 32'd0);
        check("rst_busy",  32'(bus.Busy),        32'd0);
        rst = 1'b0;
        idle_bits(2);

        // Back-to-back pair, latency, hold, ack.
        send_frame(8'h34, 0, 1'b0, 1'b0);
        send_frame(8'h12, 0, 1'b0, 1'b1);
        check("t1_word_direct", 32'(bus.SerialRead), 32'h1234);
        idle_bits(3);
        check_model("t1_hold");
        pulse_ack();
        check("t1_ack_valid", 32'(bus.SerialValid), 32'd0);
        check("t1_ack_word",  32'(bus.SerialRead),  32'h1234);

        // Overrun, then word completing in the ack cycle.
        send_frame(8'hCD, 0, 1'b0, 1'b0);
        send_frame(8'hAB, 0, 1'b0, 1'b0);
        send_frame(8'h01, 0, 1'b0, 1'b0);
        send_frame(8'h00, 0, 1'b0, 1'b0);
        check_model("t2_overrun");
        check("t2_word_direct", 32'(bus.SerialRead), 32'h0001);
        send_frame(8'h9A, 0, 1'b0, 1'b0);
        send_frame(8'h78, 0, 1'b1, 1'b0);
        check_model("t2_ack_same_cycle");

        // Short glitch aborts at the mid-start sample without side effects.
        pre_ferr  = ferr_seen;
        pre_valid = bus.SerialValid;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.RX = (c < 5) ? 1'b0 : 1'b1;
            if (c == 6)  check("t3_busy_start", 32'(bus.Busy), 32'd1);
            if (c == 20) check("t3_busy_abort", 32'(bus.Busy), 32'd0);
        end
        check("t3_no_ferr",  32'(ferr_seen),       32'(pre_ferr));
        check("t3_valid",    32'(bus.SerialValid), 32'(pre_valid));
        check_model("t3_glitch");

        // Framing error discards the byte and resets pairing.
        pulse_ack();
        send_frame(8'h55, 2, 1'b0, 1'b0);
        send_frame(8'h78, 0, 1'b0, 1'b0);
        send_frame(8'h56, 0, 1'b0, 1'b0);
        check_model("t4_frame_err");
        check("t4_word_direct", 32'(bus.SerialRead), 32'h5678);

        // Gap timeout drops a stale low byte.
        pulse_ack();
        send_frame(8'h11, 0, 1'b0, 1'b0);
        idle_bits(3);
        send_frame(8'h22, 0, 1'b0, 1'b0);
        send_frame(8'h33, 0, 1'b0, 1'b0);
        check_model("t5_gap");
        check("t5_word_direct", 32'(bus.SerialRead), 32'h3322);

        // Randomized words with mixed ack timing and optional gaps.
        for (int i = 0; i < 6; i++) begin
            lo   = 8'($urandom);
            hi   = 8'($urandom);
            mode = int'($urandom_range(0, 3));
            send_frame(lo, 0, 1'b0, 1'b0);
            if (mode == 3) idle_bits(3);
            send_frame(hi, 0, mode == 1, 1'b0);
            if (mode == 2) pulse_ack();
            check_model("rand");
        end

        // Reset during the high byte's data bits.
        idle_bits(1);
        send_frame(8'hA5, 0, 1'b0, 1'b0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            bus.RX = (c < Cpb) ? 1'b0 : 1'b1;
        end
        rst = 1'b1;
        bus.RX = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_rst_word",  32'(bus.SerialRead),  32'd0);
        check("t6_rst_valid", 32'(bus.SerialValid), 32'd0);
        check("t6_rst_ovr",   32'(bus.Overrun),     32'd0);
        check("t6_rst_ferr",  32'(bus.Frame_Error), 32'd0);
        check("t6_rst_busy",  32'(bus.Busy),        32'd0);
        model_reset();
        rst = 1'b0;
        repeat (2 * Cpb) @(negedge clk);
        check_model("t6_after_rst");
        send_frame(8'hEF, 0, 1'b0, 1'b0);
        send_frame(8'hBE, 0, 1'b0, 1'b0);
        check_model("t6_word");
        check("t6_word_direct", 32'(bus.SerialRead), 32'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
